countdown_timer: RTL and testbench
==================================

// Module: countdown_timer
// PURPOSE
//   Loadable down-counter. It is the draining counterpart to the free-running up counter.
//   It accepts a start value over a valid/ready load port, decrements on each enabled cycle,
//   and emits a one-cycle done pulse when the count expires.
//   Used as a timeout/interval source beside the counter block in the same clock domain.
// PARAMETERS
//   WIDTH    8   width of load_value and count
//   EXP_W    8   width of the expirations counter
// PORTS
//   clk          in   1      clock, rising edge
//   reset        in   1      asynchronous, active-high reset
//   load_valid   in   1      load request
//   load_ready   out  1      load may be accepted this cycle (combinational)
//   load_value   in   WIDTH  start value, sampled on accept
//   enable       in   1      decrement qualifier while running
//   abort        in   1      synchronous cancel
//   count        out  WIDTH  current remaining count (registered)
//   busy         out  1      state != IDLE (registered)
//   done         out  1      one-cycle expiry pulse (registered)
//   expirations  out  EXP_W  number of done pulses, wraps (registered)
// BEHAVIOUR
//   Reset: reset is asynchronous, active-high; clock is clk.
//   - Reset forces state=IDLE and clears count, busy, done, expirations and reload_reg to 0.
//   - Reset applies immediately, including mid-run; no done pulse is produced.
//   States: IDLE, RUN, DONE. The state is registered; busy=(state!=IDLE); done=(state==DONE).
//   Ready: load_ready = (state==IDLE) & ~abort. An accept is load_valid & load_ready at a rising edge.
//   IDLE:
//   - On accept: count<=load_value and reload_reg<=load_value.
//   - If load_value!=0, next state is RUN; if load_value==0, next state is DONE (count stays 0).
//   - enable is ignored.
//   RUN, in priority order:
//   - abort: count<=0, next state IDLE, no done pulse.
//   - enable & count==1: count<=0, next state DONE.
//   - enable: count<=count-1.
//   - otherwise hold.
//   - count never wraps below 0.
//   DONE (lasts exactly 1 cycle):
//   - done=1; expirations<=expirations+1 (modulo 2^EXP_W, 255->0 at default width).
//   - Next state IDLE; count holds 0.
//   - abort in DONE: next state IDLE; the done pulse and increment of this cycle still occur.
//   - enable is ignored.
//   Latency: for load N>0 with enable held high, count reads 0 and done=1 in the same cycle.
//   That cycle begins N edges after the accept edge.
//   Simultaneous events:
//   - abort & load_valid in IDLE: no accept.
//   - abort & enable in RUN: abort wins.
//   - load_valid outside IDLE is ignored (load_ready=0).
// CONFIGURATION
//   Macro COUNTDOWN_TIMER_AUTO_RELOAD_EN.
//   Defined:
//   - In DONE with reload_reg!=0 and abort==0: count<=reload_reg, next state RUN.
//   - done and the expirations increment still occur in that DONE cycle.
//   - Period is reload_reg+1 cycles with enable held high.
//   - With reload_reg==0, or with abort asserted, DONE goes to IDLE.
//   - abort in RUN still returns the block to IDLE.
//   Undefined:
//   - DONE always goes to IDLE.
//   - reload_reg may be optimised away.
// TESTING
//   1 Load 3, enable=1:
//     - count reads 3,2,1,0 on the edges after accept.
//     - done=1 and busy=1 in the cycle that count==0.
//     - The next cycle shows busy=0, load_ready=1, expirations=1.
//   2 Load 4, enable pattern 1,0,0,1,1,1:
//     - count reads 4,3,3,3,2,1,0; done asserts once.
//   3 Load 0: the next cycle shows done=1 and count=0; the cycle after shows IDLE with expirations+1.
//   4 Load 10, abort at count=5:
//     - Next cycle: count=0, busy=0, done never asserts, expirations unchanged.
//     - abort together with load_valid in IDLE gives load_ready=0 and no accept.
//   5 Load 200 and assert reset at count=150:
//     - Outputs clear immediately.
//     - A new load of 2 completes normally.
//     - 256 expirations wrap expirations to 0.
//   6 AUTO_RELOAD_EN, load 2, enable=1:
//     - done pulses every 3 cycles and count cycles 2,1,0.
//     - abort in RUN, or in a DONE cycle, returns the block to IDLE.
//     - Without the macro, a single done pulse then IDLE.

Source files
------------

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter used as a timeout/interval source.
//
// A start value is accepted over a valid/ready load port while idle. The count then
// decrements on every enabled cycle; when it expires the block spends exactly one cycle
// in DONE, raising a one-cycle done pulse and bumping a wrapping expirations counter.
// A zero load goes straight to DONE. abort cancels a run without a done pulse.
//
// Optional feature (macro COUNTDOWN_TIMER_AUTO_RELOAD_EN): when defined, DONE reloads the
// last accepted start value and re-enters RUN, unless that value is 0 or abort is high.
// This gives a periodic done pulse every reload+1 enabled cycles.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous, active-high reset
//   load_valid   in   load request
//   load_ready   out  load may be accepted this cycle (combinational: idle and no abort)
//   load_value   in   start value, sampled on accept
//   enable       in   decrement qualifier while running
//   abort        in   synchronous cancel
//   count        out  remaining count (registered)
//   busy         out  state != IDLE (registered)
//   done         out  one-cycle expiry pulse (registered)
//   expirations  out  number of done pulses, wraps (registered)
module countdown_timer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned EXP_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [EXP_W-1:0] expirations
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic             accept;

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  assign load_ready = (state_q == StIdle) & ~abort;
  assign accept     = load_valid & load_ready;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    exp_d   = exp_q;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          count_d = load_value;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
          reload_d = load_value;
`endif
          // A zero load expires immediately: straight to the done cycle.
          state_d = (load_value != '0) ? StRun : StDone;
        end
      end
      StRun: begin
        if (abort) begin
          count_d = '0;
          state_d = StIdle;
        end else if (enable) begin
          if (count_q == WIDTH'(1)) begin
            count_d = '0;
            state_d = StDone;
          end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end
      StDone: begin
        // The pulse and the increment happen even if abort is high this cycle.
        exp_d   = exp_q + EXP_W'(1);
        count_d = '0;
        state_d = StIdle;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
        if ((reload_q != '0) && !abort) begin
          count_d = reload_q;
          state_d = StRun;
        end
`endif
      end
      default: begin
        count_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= '0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      exp_q   <= exp_d;
    end
  end

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end
`endif

  // Flags decode straight from the state register, so they carry no input paths.
  assign count       = count_q;
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign expirations = exp_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed testbench for countdown_timer. Inputs change 1 time unit after a rising edge
// and outputs are sampled there as well, away from the active edge.
module tb_countdown_timer;

  logic       clk;
  logic       reset;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_value;
  logic       enable;
  logic       abort;
  logic [7:0] count;
  logic       busy;
  logic       done;
  logic [7:0] expirations;

  int n_tests = 0;
  int n_fail  = 0;

  countdown_timer #(
    .WIDTH (8),
    .EXP_W (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_value  (load_value),
    .enable      (enable),
    .abort       (abort),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .expirations (expirations)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int unsigned obs, input int unsigned expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  initial begin
    int         done_seen;
    logic       en_pat[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] cnt_exp[6] = '{8'd3, 8'd3, 8'd3, 8'd2, 8'd1, 8'd0};
    logic       dn_exp[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    reset      = 1'b1;
    load_valid = 1'b0;
    load_value = 8'd0;
    enable     = 1'b0;
    abort      = 1'b0;
    tick();
    tick();
    check("rst_count", 32'(count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_exp", 32'(expirations), 0);
    check("rst_ready", 32'(load_ready), 1);
    reset = 1'b0;
    tick();

    // 1: load 3, enable held high.
    enable     = 1'b1;
    load_valid = 1'b1;
    load_value = 8'd3;
    #1;
    check("t1_ready", 32'(load_ready), 1);
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t1_count", 32'(count), 32'(3 - i));
      check("t1_done", 32'(done), (i == 3) ? 1 : 0);
      check("t1_busy", 32'(busy), 1);
      if (i < 3) tick();
    end
    tick();
    check("t1_idle_busy", 32'(busy), 0);
    check("t1_idle_ready", 32'(load_ready), 1);
    check("t1_idle_exp", 32'(expirations), 1);

    // 2: load 4, enable pattern 1,0,0,1,1,1.
    enable     = 1'b0;
    load_valid = 1'b1;
    load_value = 8'd4;
    tick();
    load_valid = 1'b0;
    check("t2_count_load", 32'(count), 4);
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      enable = en_pat[i];
      tick();
      check("t2_count", 32'(count), 32'(cnt_exp[i]));
      check("t2_done", 32'(done), 32'(dn_exp[i]));
      if (done) done_seen++;
    end
    enable = 1'b0;
    tick();
    if (done) done_seen++;
    check("t2_done_once", 32'(done_seen), 1);
    check("t2_exp", 32'(expirations), 2);
    check("t2_busy", 32'(busy), 0);

    // 3: load 0 expires immediately.
    load_valid = 1'b1;
    load_value = 8'd0;
    tick();
    load_valid = 1'b0;
    check("t3_done", 32'(done), 1);
    check("t3_count", 32'(count), 0);
    check("t3_busy", 32'(busy), 1);
    tick();
    check("t3_idle", 32'(busy), 0);
    check("t3_done_off", 32'(done), 0);
    check("t3_exp", 32'(expirations), 3);

    // 4: load 10, abort at count 5; then abort blocks a load in IDLE.
    enable     = 1'b1;
    load_valid = 1'b1;
    load_value = 8'd10;
    tick();
    load_valid = 1'b0;
    done_seen  = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) done_seen++;
    end
    check("t4_count5", 32'(count), 5);
    abort = 1'b1;
    tick();
    if (done) done_seen++;
    check("t4_abort_count", 32'(count), 0);
    check("t4_abort_busy", 32'(busy), 0);
    check("t4_abort_exp", 32'(expirations), 3);
    load_valid = 1'b1;
    load_value = 8'd7;
    #1;
    check("t4_ready_abort", 32'(load_ready), 0);
    tick();
    if (done) done_seen++;
    check("t4_no_accept_busy", 32'(busy), 0);
    check("t4_no_accept_count", 32'(count), 0);
    check("t4_no_done", 32'(done_seen), 0);
    abort      = 1'b0;
    load_valid = 1'b0;

    // 5: async reset mid-run, then a normal load, then expirations wrap.
    load_valid = 1'b1;
    load_value = 8'd200;
    tick();
    load_valid = 1'b0;
    repeat (50) tick();
    check("t5_count150", 32'(count), 150);
    reset = 1'b1;
    #1;
    check("t5_rst_count", 32'(count), 0);
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_done", 32'(done), 0);
    check("t5_rst_exp", 32'(expirations), 0);
    tick();
    reset      = 1'b0;
    load_valid = 1'b1;
    load_value = 8'd2;
    tick();
    load_valid = 1'b0;
    check("t5_l2_c2", 32'(count), 2);
    tick();
    check("t5_l2_c1", 32'(count), 1);
    tick();
    check("t5_l2_done", 32'(done), 1);
    tick();
    check("t5_l2_idle", 32'(busy), 0);
    check("t5_l2_exp", 32'(expirations), 1);
    for (int i = 0; i < 255; i++) begin
      load_valid = 1'b1;
      load_value = 8'd0;
      tick();
      load_valid = 1'b0;
      tick();
      if (i == 253) check("t5_exp255", 32'(expirations), 255);
    end
    check("t5_exp_wrap", 32'(expirations), 0);

    // 6: load 2 with enable high; auto-reload behaviour depends on the build.
    enable     = 1'b1;
    load_valid = 1'b1;
    load_value = 8'd2;
    tick();
    load_valid = 1'b0;
    check("t6_c2", 32'(count), 2);
    tick();
    check("t6_c1", 32'(count), 1);
    tick();
    check("t6_done1", 32'(done), 1);
    check("t6_c0", 32'(count), 0);
    tick();
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    check("t6_reload_c2", 32'(count), 2);
    check("t6_reload_busy", 32'(busy), 1);
    check("t6_reload_done", 32'(done), 0);
    check("t6_exp1", 32'(expirations), 1);
    tick();
    check("t6_reload_c1", 32'(count), 1);
    tick();
    check("t6_done2", 32'(done), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_abort_done_busy", 32'(busy), 0);
    check("t6_abort_done_count", 32'(count), 0);
    check("t6_abort_done_exp", 32'(expirations), 2);
    load_valid = 1'b1;
    load_value = 8'd2;
    tick();
    load_valid = 1'b0;
    abort      = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_abort_run_busy", 32'(busy), 0);
    check("t6_abort_run_count", 32'(count), 0);
    check("t6_abort_run_exp", 32'(expirations), 2);
`else
    check("t6_idle_busy", 32'(busy), 0);
    check("t6_idle_count", 32'(count), 0);
    check("t6_exp1", 32'(expirations), 1);
    tick();
    check("t6_stay_idle", 32'(busy), 0);
    check("t6_no_second_done", 32'(done), 0);
    check("t6_exp_hold", 32'(expirations), 1);
`endif
    enable = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
